// File: rtl/spi_master_if.sv
// rtl/spi_master_if.sv - request/response bus between a host and spi_master
interface spi_master_if #(
  parameter int DATA_W = 16,
  parameter int DIV_W  = 8,
  parameter int LEN_W  = 5
);
  logic              req_valid;
  logic              req_ready;
  logic [DATA_W-1:0] tx_data;
  logic [LEN_W-1:0]  len;
  logic [DIV_W-1:0]  div;
  logic              resp_valid;
  logic [DATA_W-1:0] rx_data;
  logic              busy;

  modport master (
    output req_valid, tx_data, len, div,
    input  req_ready, resp_valid, rx_data, busy
  );

  modport slave (
    input  req_valid, tx_data, len, div,
    output req_ready, resp_valid, rx_data, busy
  );
endinterface

// File: rtl/spi_master.sv
// rtl/spi_master.sv - single-slave mode-0 SPI initiator, MSB-first, 1..DATA_W bits per transfer
module spi_master #(
  parameter int DATA_W = 16,
  parameter int DIV_W  = 8,
  parameter int LEN_W  = 5
) (
  input  logic       clock,
  input  logic       reset,
  spi_master_if.slave bus,
  output logic       sck,
  output logic       ss,
  output logic       mosi,
  input  logic       miso
);
  typedef enum logic [2:0] {IDLE, LEAD, XFER, TRAIL, GAP} state_t;

  state_t            state;
  logic [DIV_W:0]    cnt;
  logic [DIV_W-1:0]  div_q;
  logic [LEN_W-1:0]  bits_left;
  logic [DATA_W-1:0] tx_sh;
  logic [DATA_W-1:0] rx_sh;
  logic [LEN_W-1:0]  len_eff;
  logic [DATA_W-1:0] tx_aligned;
  logic              phase_end;

  // Left-align the word so the first bit to send is always tx_sh[DATA_W-1].
  always_comb begin
    len_eff = bus.len;
    if (bus.len == '0 || bus.len > LEN_W'(DATA_W))
      len_eff = LEN_W'(DATA_W);
    tx_aligned = bus.tx_data << (LEN_W'(DATA_W) - len_eff);
  end

  assign phase_end = (cnt == '0);

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state          <= IDLE;
      cnt            <= '0;
      div_q          <= '0;
      bits_left      <= '0;
      tx_sh          <= '0;
      rx_sh          <= '0;
      sck            <= 1'b0;
      ss             <= 1'b1;
      mosi           <= 1'b1;
      bus.resp_valid <= 1'b0;
      bus.rx_data    <= '0;
      bus.busy       <= 1'b0;
      bus.req_ready  <= 1'b1;
    end else begin
      bus.resp_valid <= 1'b0;
      case (state)
        IDLE: begin
          if (bus.req_valid && bus.req_ready) begin
            state         <= LEAD;
            div_q         <= bus.div;
            cnt           <= {1'b0, bus.div};
            bits_left     <= len_eff;
            tx_sh         <= tx_aligned;
            rx_sh         <= '0;
            ss            <= 1'b0;
            mosi          <= tx_aligned[DATA_W-1];
            bus.req_ready <= 1'b0;
            bus.busy      <= 1'b1;
          end
        end
        LEAD: begin
          if (phase_end) begin
            state <= XFER;
            sck   <= 1'b1;
            cnt   <= {1'b0, div_q};
          end else begin
            cnt <= cnt - (DIV_W+1)'(1);
          end
        end
        XFER: begin
          if (!phase_end) begin
            cnt <= cnt - (DIV_W+1)'(1);
          end else begin
            cnt <= {1'b0, div_q};
            if (sck) begin
              // Last cycle of the high phase: capture miso, then fall and shift.
              sck       <= 1'b0;
              rx_sh     <= {rx_sh[DATA_W-2:0], miso};
              bits_left <= bits_left - LEN_W'(1);
              tx_sh     <= tx_sh << 1;
              mosi      <= (bits_left == LEN_W'(1)) ? 1'b1 : tx_sh[DATA_W-2];
            end else if (bits_left == '0) begin
              state <= TRAIL;
            end else begin
              sck <= 1'b1;
            end
          end
        end
        TRAIL: begin
          if (phase_end) begin
            state          <= GAP;
            cnt            <= {1'b0, div_q};
            ss             <= 1'b1;
            bus.resp_valid <= 1'b1;
            bus.rx_data    <= rx_sh;
          end else begin
            cnt <= cnt - (DIV_W+1)'(1);
          end
        end
        GAP: begin
          if (phase_end) begin
            state         <= IDLE;
            bus.req_ready <= 1'b1;
            bus.busy      <= 1'b0;
          end else begin
            cnt <= cnt - (DIV_W+1)'(1);
          end
        end
        default: begin
          state          <= IDLE;
          cnt            <= '0;
          div_q          <= '0;
          bits_left      <= '0;
          tx_sh          <= '0;
          rx_sh          <= '0;
          sck            <= 1'b0;
          ss             <= 1'b1;
          mosi           <= 1'b1;
          bus.resp_valid <= 1'b0;
          bus.rx_data    <= '0;
          bus.busy       <= 1'b0;
          bus.req_ready  <= 1'b1;
        end
      endcase
    end
  end
endmodule

// File: doc/spi_master.md
Name: spi_master

Overview:
- Single-slave SPI initiator, mode 0 (CPOL=0, CPHA=0), MSB-first.
- Drives sck/ss/mosi and samples miso; pairs with the 8-bit receive-then-transmit SPI peripheral models on the NPC perip bus.
- A bus-side valid/ready request starts one transfer of 1..DATA_W bits.
- Received word returns on a one-cycle resp_valid pulse.

Parameters:
- DATA_W, 16: maximum bits per transfer; width of tx_data/rx_data.
- DIV_W, 8: width of the clock-divider input.
- LEN_W, 5: width of len; must satisfy 2^LEN_W > DATA_W.

Ports:
- clock  input  1  system clock; all logic on posedge.
- reset  input  1  asynchronous, active-high reset.
- req_valid  input  1  transfer request.
- req_ready  output  1  high only in IDLE; transfer accepted on req_valid && req_ready at posedge.
- tx_data  input  DATA_W  word to send, occupying bits [len-1:0]; sampled at acceptance.
- len  input  LEN_W  bits to transfer; sampled at acceptance. A value of 0 or >DATA_W means DATA_W.
- div  input  DIV_W  half-period of sck is h = div+1 clock cycles; sampled at acceptance.
- resp_valid  output  1  one-cycle pulse when the transfer completes.
- rx_data  output  DATA_W  received word, held until the next resp_valid.
- busy  output  1  high in any state other than IDLE.
- sck  output  1  SPI clock; idles low.
- ss  output  1  active-low slave select; idles high.
- mosi  output  1  serial data out; idles high.
- miso  input  1  serial data in.

Behaviour:
- Reset values (asynchronous, immediate):
  - sck=0, ss=1, mosi=1.
  - resp_valid=0, rx_data=0, busy=0, req_ready=1.
  - FSM in IDLE; all counters cleared.
- FSM states: IDLE, LEAD, XFER, TRAIL, GAP.
  - IDLE: on acceptance, latch tx, len (after clamp), and h. Next cycle: ss=0, mosi=tx[len-1]; go to LEAD.
  - LEAD: ss low, sck low for h cycles, then go to XFER.
  - XFER: sck alternates high and low, h cycles each phase, for len full periods.
    - miso is sampled in the last cycle of each high phase, i.e. the cycle before sck falls. This tolerates slaves that update miso on posedge sck.
    - On each falling edge, mosi advances to the next lower bit.
    - After the final falling edge, mosi returns to 1 and the FSM goes to TRAIL.
  - TRAIL: ss low, sck low for h cycles. Then in the same cycle: ss=1, resp_valid=1, rx_data updated. Go to GAP.
  - GAP: ss high for h cycles, then IDLE. Minimum ss-high gap between transfers is h cycles.
- Timing:
  - Let T be the accepting posedge. resp_valid is high in cycle T+(2*len+2)*h+1.
  - ss is low for exactly (2*len+2)*h cycles.
- rx assembly:
  - Bits shift in MSB-first.
  - The first sampled bit lands in rx_data[len-1] and the last in rx_data[0].
  - rx_data[DATA_W-1:len] = 0.
- Divider:
  - One DIV_W+1-bit down-counter reloaded with div at every phase boundary.
  - div=0 gives sck = clock/2.
  - div changes during a transfer have no effect.
- req_valid while busy: ignored, because req_ready=0. req_valid may drop without consequence while in IDLE.
- Reset mid-transfer: all outputs return to reset values immediately, ss deasserts, and no resp_valid is produced.
- Illegal FSM state: return to IDLE with the reset output values.

Test Plan:
- Reset: assert reset mid-cycle with no clock edge -> sck=0, ss=1, mosi=1, req_ready=1, resp_valid=0, rx_data=0 immediately.
- Basic loopback:
  - Stimulus: div=0, len=16, tx_data=0xA500. Bench slave is mode-0, receives 8 bits, then echoes them on the next 8 posedges, with miso=1 while receiving.
  - Required: exactly 16 sck rising edges; slave captures 0xA5; rx_data=0xFFA5; resp_valid at T+35.
- Divider timing:
  - Stimulus: div=3, len=8, tx_data=0x3C, miso tied to a bench shift register preloaded with 0x96, advancing on falling sck.
  - Required: every sck high and low phase lasts 4 cycles; ss low for 72 cycles; resp_valid at T+73; rx_data=0x0096.
- Length edge cases:
  - len=1, tx_data=0x0001, miso=1 -> one sck pulse, mosi=1 during it, rx_data=0x0001.
  - len=0, tx_data=0x8001 -> 16 sck pulses, first mosi bit 1, last mosi bit 1.
- Back-to-back:
  - Stimulus: req_valid held high across two requests, div=1.
  - Required: req_ready=0 from T+1 until the GAP ends; ss high for ≥2 cycles between transfers; exactly two resp_valid pulses.
- Reset mid-operation: assert reset during the 5th bit of a 16-bit transfer -> ss=1, sck=0 immediately; no resp_valid; a new request after reset completes correctly.
